fir_coeff_loader: RTL and testbench
===================================

// Module: fir_coeff_loader
// PURPOSE
//  Upstream configuration stage for the FIR filter. Host writes signed coefficient words (SFix<1,DataWidth-1>)
//  into a staging bank; on commit, the bank is serialised into the filter's bit-serial coefficient port
//  (coeff_load/coeff_bit) while the filter is idle. Also latches the symmetric/anti-symmetric mode flag
//  and raises hold so the sample scheduler suppresses filter start pulses during a load.
// PARAMETERS
//  DataWidth  12  coefficient word width, bits
//  NCoeffs    5   coefficients held by the filter ((NTaps+1)/2)
//  AddrWidth  $clog2(NCoeffs) (localparam)  staging address width
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous reset, active-high
//  wr_en          in   1          staging write strobe
//  wr_addr        in   AddrWidth  staging index; index 0 = coefficient applied to outermost taps
//  wr_data        in   DataWidth  signed coefficient word
//  cfg_sym        in   1          mode to apply with next commit (1 = symmetric)
//  commit         in   1          pulse: request transfer of staging bank to filter
//  fir_busy       in   1          filter state machine not IDLE
//  coeff_load     out  1          to filter coeff_load_in
//  coeff_bit      out  1          to filter coeff_in
//  sym_coeffs     out  1          to filter symCoeffs
//  hold           out  1          high while a load is pending or in progress; gates filter start
//  load_done      out  1          one-cycle pulse after last bit shifted
// BEHAVIOUR
//  Reset: all outputs 0, staging bank and shift register 0, state IDLE, pending cleared.
//  Staging: wr_en writes wr_data to bank[wr_addr] at clock edge; wr_addr >= NCoeffs ignored.
//   Writes allowed in every state; they never disturb a load in progress.
//  FSM IDLE -> WAIT -> SHIFT -> DONE -> IDLE.
//   IDLE: commit -> WAIT; copy bank (incl. same-cycle write, write-through) into shift reg,
//         capture cfg_sym into sym_shadow.
//   WAIT: hold=1; stay while fir_busy; !fir_busy -> SHIFT.
//   SHIFT: exactly DataWidth*NCoeffs cycles, coeff_load=1, hold=1; bit counter 0..DataWidth*NCoeffs-1.
//   DONE: one cycle, coeff_load=0, hold=1, load_done=1, sym_coeffs <= sym_shadow; -> IDLE,
//         or -> WAIT if pending set (re-snapshot bank and cfg_sym, clear pending).
//  Bit order: coeff_bit = bank[NCoeffs-1] MSB first ... bank[NCoeffs-1] LSB, then bank[NCoeffs-2] MSB,
//   ..., bank[0] LSB last; after the load filter coeffs[k] == bank[k].
//  coeff_load/coeff_bit/hold/load_done registered (driven from state/shift reg, no comb path from inputs).
//  Latency: commit at edge k, fir_busy=0 -> coeff_load high k+2..k+(DataWidth*NCoeffs+1), load_done at
//   cycle k+DataWidth*NCoeffs+2 (62 cycles after commit for defaults).
//  commit outside IDLE: sets pending (multiple commits collapse to one); serviced from DONE.
//  fir_busy rising during SHIFT: ignored (hold guarantees no new start; filter already in COEFF_LD).
//  Reset mid-load: next cycle coeff_load=0, hold=0; filter left partially loaded; sym_coeffs=0;
//   host must rewrite bank and recommit.
// CONFIGURATION
//  FIR_COEFF_READBACK_EN defined: adds ports rd_addr in AddrWidth, rd_data out DataWidth;
//   rd_data = bank[rd_addr] combinationally, 0 for rd_addr >= NCoeffs.
//  Not defined: ports absent; no read mux synthesised. All other behaviour identical.
// TESTING
//  Reset: rst=1 two cycles -> all outputs 0; then commit with empty bank -> 60 zero bits, load_done.
//  Write bank = {0x7FF,0x400,0x000,0xC00,0x801}, commit, fir_busy=0 -> first bit 1 (0x801 MSB),
//   60 load cycles, load_done at commit+62; filter model coeffs match bank.
//  fir_busy=1 for 10 cycles after commit -> hold=1 all along, coeff_load stays 0 until fir_busy falls.
//  Commit at SHIFT bit 30 with bank[2] rewritten 0x123 -> first load unchanged, second load follows DONE
//   with bank[2]=0x123, two load_done pulses.
//  cfg_sym=0 at commit, toggled to 1 during SHIFT -> sym_coeffs=0 at DONE; wr_addr=5 write -> no change.
//  rst asserted at SHIFT bit 20 -> next cycle coeff_load=0, hold=0, sym_coeffs=0; readback (macro on)
//   returns 0 for all entries.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// Purpose : stages signed FIR coefficients and serialises them MSB-first into the filter's bit-serial load port.
// Latency : commit at edge k with filter idle -> coeff_load high k+2..k+NBits+1, load_done pulse at k+NBits+2.
// Backpr. : waits in WAIT while fir_busy; commits arriving mid-load collapse into one pending reload.
// Optional: FIR_COEFF_READBACK_EN adds a combinational staging-bank read port (rd_addr/rd_data).
module fir_coeff_loader #(
   parameter int   DataWidth = 12,
   parameter int   NCoeffs   = 5,
   localparam int  AddrWidth = $clog2(NCoeffs)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [AddrWidth-1:0] wr_addr,
   input  logic [DataWidth-1:0] wr_data,
`ifdef FIR_COEFF_READBACK_EN
   input  logic [AddrWidth-1:0] rd_addr,
   output logic [DataWidth-1:0] rd_data,
`endif
   input  logic                 cfg_sym,
   input  logic                 commit,
   input  logic                 fir_busy,
   output logic                 coeff_load,
   output logic                 coeff_bit,
   output logic                 sym_coeffs,
   output logic                 hold,
   output logic                 load_done
);

   localparam int NBits    = DataWidth * NCoeffs;
   localparam int CntWidth = $clog2(NBits);
   localparam logic [CntWidth-1:0]  LastBit  = CntWidth'(NBits - 1);
   localparam logic [AddrWidth:0]   NCoeffsA = (AddrWidth + 1)'(NCoeffs);

   typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;

   logic [DataWidth-1:0] bank [NCoeffs];
   logic [NBits-1:0]     shift_q;
   logic [NBits-1:0]     snap;
   logic [CntWidth-1:0]  bit_cnt;
   logic                 sym_shadow;
   logic                 pending;
   logic                 wr_ok;
   state_t               state;

   // Out-of-range staging addresses are dropped rather than aliased.
   assign wr_ok = wr_en && ({1'b0, wr_addr} < NCoeffsA);

   // Staging bank: host writes land here at any time; the shifter works from its own copy.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCoeffs; i++) bank[i] <= '0;
      end else if (wr_ok) begin
         bank[wr_addr] <= wr_data;
      end
   end

   // Bank image for a snapshot, with a same-cycle write passed straight through.
   // bank[NCoeffs-1] sits in the top bits so it leaves the shifter first.
   always_comb begin
      snap = '0;
      for (int i = 0; i < NCoeffs; i++) begin
         snap[i*DataWidth +: DataWidth] = (wr_ok && (wr_addr == AddrWidth'(i))) ? wr_data : bank[i];
      end
   end

`ifdef FIR_COEFF_READBACK_EN
   // Host readback of the staging bank; unused addresses read as zero.
   always_comb begin
      rd_data = '0;
      if ({1'b0, rd_addr} < NCoeffsA) rd_data = bank[rd_addr];
   end
`endif

   // Load sequencer: snapshot, wait for the filter to go idle, shift every bit, then report.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         shift_q    <= '0;
         bit_cnt    <= '0;
         sym_shadow <= 1'b0;
         pending    <= 1'b0;
         coeff_load <= 1'b0;
         coeff_bit  <= 1'b0;
         sym_coeffs <= 1'b0;
         hold       <= 1'b0;
         load_done  <= 1'b0;
      end else begin
         load_done <= 1'b0;
         case (state)
            IDLE: begin
               if (commit) begin
                  state      <= WAIT;
                  shift_q    <= snap;
                  sym_shadow <= cfg_sym;
                  hold       <= 1'b1;
               end
            end
            WAIT: begin
               if (commit) pending <= 1'b1;
               if (!fir_busy) begin
                  state      <= SHIFT;
                  bit_cnt    <= '0;
                  coeff_load <= 1'b1;
                  coeff_bit  <= shift_q[NBits-1];
                  shift_q    <= {shift_q[NBits-2:0], 1'b0};
               end
            end
            SHIFT: begin
               // fir_busy is not looked at here: hold already keeps the filter from starting.
               if (commit) pending <= 1'b1;
               if (bit_cnt == LastBit) begin
                  state      <= DONE;
                  coeff_load <= 1'b0;
                  coeff_bit  <= 1'b0;
                  load_done  <= 1'b1;
                  sym_coeffs <= sym_shadow;
               end else begin
                  bit_cnt    <= bit_cnt + CntWidth'(1);
                  coeff_bit  <= shift_q[NBits-1];
                  shift_q    <= {shift_q[NBits-2:0], 1'b0};
               end
            end
            DONE: begin
               // A commit seen during the load (or right now) restarts from a fresh snapshot.
               if (pending || commit) begin
                  state      <= WAIT;
                  shift_q    <= snap;
                  sym_shadow <= cfg_sym;
                  pending    <= 1'b0;
               end else begin
                  state      <= IDLE;
                  hold       <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: serial load ordering, timing, busy wait,
// pending reload, mode latching, address range and reset during a load.
module tb_fir_coeff_loader;

   localparam int DW = 12;
   localparam int NC = 5;
   localparam int AW = 3;
   localparam int NB = DW * NC;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          cfg_sym = 1'b0;
   logic          commit = 1'b0;
   logic          fir_busy = 1'b0;
   logic          coeff_load, coeff_bit, sym_coeffs, hold, load_done;
`ifdef FIR_COEFF_READBACK_EN
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] rd_data;
`endif

   int checks = 0;
   int errors = 0;

   // Results of the most recent observation window.
   int            obs_first_ld, obs_nld, obs_ndone, obs_hold_lo;
   int            obs_done [2];
   logic          obs_first_bit, obs_sym_pre, obs_sym_done;
   logic [NB-1:0] obs_cap [2];

   always #5 clk = ~clk;

   fir_coeff_loader #(.DataWidth(DW), .NCoeffs(NC)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
`ifdef FIR_COEFF_READBACK_EN
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
`endif
      .cfg_sym    (cfg_sym),
      .commit     (commit),
      .fir_busy   (fir_busy),
      .coeff_load (coeff_load),
      .coeff_bit  (coeff_bit),
      .sym_coeffs (sym_coeffs),
      .hold       (hold),
      .load_done  (load_done)
   );

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk);
      #1 wr_en = 1'b0;
   endtask

   // Pulse commit (optionally with a same-cycle write); returns just after the commit edge.
   task automatic do_commit(input logic sym, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      cfg_sym = sym; commit = 1'b1;
      wr_en = wr; wr_addr = a; wr_data = d;
      @(posedge clk);
   endtask

   // Watch ncyc cycles after a commit edge; cycle n is the value the DUT presents at edge k+n.
   // Filter model: each coeff_load cycle shifts coeff_bit into the low end of a NB-bit register.
   task automatic observe(input int ncyc, input int busy_drop, input int inj_n, input logic inj_wr,
                          input logic [AW-1:0] inj_addr, input logic [DW-1:0] inj_data,
                          input logic inj_commit, input logic inj_sym);
      obs_first_ld = 0; obs_nld = 0; obs_ndone = 0; obs_hold_lo = 0;
      obs_done[0] = 0; obs_done[1] = 0; obs_cap[0] = '0; obs_cap[1] = '0;
      obs_first_bit = 1'b0; obs_sym_pre = 1'b0; obs_sym_done = 1'b0;
      for (int n = 1; n <= ncyc; n++) begin
         @(negedge clk);
         if (n == 1) obs_sym_pre = sym_coeffs;
         if (coeff_load === 1'b1) begin
            if (obs_nld == 0) begin obs_first_ld = n; obs_first_bit = coeff_bit; end
            obs_nld++;
            if (obs_ndone == 0) obs_cap[0] = {obs_cap[0][NB-2:0], coeff_bit};
            else                obs_cap[1] = {obs_cap[1][NB-2:0], coeff_bit};
         end
         if (load_done === 1'b1) begin
            if (obs_ndone < 2) obs_done[obs_ndone] = n;
            obs_ndone++;
            obs_sym_done = sym_coeffs;
         end
         if (hold !== 1'b1 && obs_hold_lo == 0) obs_hold_lo = n;
         wr_en = 1'b0; commit = 1'b0;
         if (n == busy_drop) fir_busy = 1'b0;
         if (n == inj_n) begin
            wr_en = inj_wr; wr_addr = inj_addr; wr_data = inj_data;
            commit = inj_commit; cfg_sym = inj_sym;
         end
      end
      wr_en = 1'b0; commit = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (coeff_load !== 1'b0) begin errors++; $display("FAIL rst_coeff_load got %b exp 0", coeff_load); end
      checks++; if (coeff_bit  !== 1'b0) begin errors++; $display("FAIL rst_coeff_bit got %b exp 0", coeff_bit); end
      checks++; if (sym_coeffs !== 1'b0) begin errors++; $display("FAIL rst_sym got %b exp 0", sym_coeffs); end
      checks++; if (hold       !== 1'b0) begin errors++; $display("FAIL rst_hold got %b exp 0", hold); end
      checks++; if (load_done  !== 1'b0) begin errors++; $display("FAIL rst_load_done got %b exp 0", load_done); end
      rst = 1'b0;
      // Empty bank: 60 zero bits then load_done.
      do_commit(1'b0, 1'b0, '0, '0);
      observe(70, 0, 0, 1'b0, '0, '0, 1'b0, 1'b0);
      checks++; if (obs_first_ld !== 2)  begin errors++; $display("FAIL empty_first_ld got %0d exp 2", obs_first_ld); end
      checks++; if (obs_nld !== 60)      begin errors++; $display("FAIL empty_nld got %0d exp 60", obs_nld); end
      checks++; if (obs_cap[0] !== '0)   begin errors++; $display("FAIL empty_bits got %h exp 0", obs_cap[0]); end
      checks++; if (obs_done[0] !== 62 || obs_ndone !== 1) begin errors++; $display("FAIL empty_done got %0d x%0d exp 62 x1", obs_done[0], obs_ndone); end
      checks++; if (obs_hold_lo !== 63)  begin errors++; $display("FAIL empty_hold_lo got %0d exp 63", obs_hold_lo); end
   endtask

   task automatic test_load;
      do_write(3'd1, 12'h400);
      do_write(3'd2, 12'h000);
      do_write(3'd3, 12'hC00);
      do_write(3'd4, 12'h801);
`ifdef FIR_COEFF_READBACK_EN
      @(negedge clk); rd_addr = 3'd3; #1;
      checks++; if (rd_data !== 12'hC00) begin errors++; $display("FAIL readback3 got %h exp c00", rd_data); end
`endif
      // bank[0] written in the commit cycle itself must be in the snapshot.
      do_commit(1'b1, 1'b1, 3'd0, 12'h7FF);
      observe(70, 0, 0, 1'b0, '0, '0, 1'b0, 1'b1);
      checks++; if (obs_first_bit !== 1'b1) begin errors++; $display("FAIL load_first_bit got %b exp 1", obs_first_bit); end
      checks++; if (obs_first_ld !== 2)     begin errors++; $display("FAIL load_first_ld got %0d exp 2", obs_first_ld); end
      checks++; if (obs_nld !== 60)         begin errors++; $display("FAIL load_nld got %0d exp 60", obs_nld); end
      checks++; if (obs_cap[0] !== 60'h801C000004007FF) begin errors++; $display("FAIL load_bits got %h exp 801c000004007ff", obs_cap[0]); end
      checks++; if (obs_done[0] !== 62)     begin errors++; $display("FAIL load_done_cyc got %0d exp 62", obs_done[0]); end
      checks++; if (obs_sym_pre !== 1'b0 || obs_sym_done !== 1'b1) begin errors++; $display("FAIL load_sym got %b->%b exp 0->1", obs_sym_pre, obs_sym_done); end
   endtask

   task automatic test_busy_wait;
      @(negedge clk); fir_busy = 1'b1;
      do_commit(1'b1, 1'b0, '0, '0);
      observe(80, 11, 0, 1'b0, '0, '0, 1'b0, 1'b1);
      checks++; if (obs_first_ld !== 12) begin errors++; $display("FAIL busy_first_ld got %0d exp 12", obs_first_ld); end
      checks++; if (obs_nld !== 60)      begin errors++; $display("FAIL busy_nld got %0d exp 60", obs_nld); end
      checks++; if (obs_done[0] !== 72)  begin errors++; $display("FAIL busy_done got %0d exp 72", obs_done[0]); end
      checks++; if (obs_hold_lo !== 73)  begin errors++; $display("FAIL busy_hold_lo got %0d exp 73", obs_hold_lo); end
      checks++; if (obs_cap[0] !== 60'h801C000004007FF) begin errors++; $display("FAIL busy_bits got %h exp 801c000004007ff", obs_cap[0]); end
   endtask

   task automatic test_back_to_back;
      // Commit plus a rewrite of bank[2] while bit 30 is being shifted.
      do_commit(1'b1, 1'b0, '0, '0);
      observe(130, 0, 31, 1'b1, 3'd2, 12'h123, 1'b1, 1'b1);
      checks++; if (obs_ndone !== 2) begin errors++; $display("FAIL b2b_ndone got %0d exp 2", obs_ndone); end
      checks++; if (obs_done[0] !== 62 || obs_done[1] !== 124) begin errors++; $display("FAIL b2b_done got %0d,%0d exp 62,124", obs_done[0], obs_done[1]); end
      checks++; if (obs_cap[0] !== 60'h801C000004007FF) begin errors++; $display("FAIL b2b_first got %h exp 801c000004007ff", obs_cap[0]); end
      checks++; if (obs_cap[1] !== 60'h801C001234007FF) begin errors++; $display("FAIL b2b_second got %h exp 801c001234007ff", obs_cap[1]); end
      checks++; if (obs_nld !== 120)  begin errors++; $display("FAIL b2b_nld got %0d exp 120", obs_nld); end
      checks++; if (obs_hold_lo !== 125) begin errors++; $display("FAIL b2b_hold_lo got %0d exp 125", obs_hold_lo); end
   endtask

   task automatic test_sym_and_range;
      // Mode changes after commit and an out-of-range write during SHIFT must not matter.
      do_commit(1'b0, 1'b0, '0, '0);
      observe(70, 0, 20, 1'b1, 3'd5, 12'hABC, 1'b0, 1'b1);
      checks++; if (obs_sym_pre !== 1'b1 || obs_sym_done !== 1'b0) begin errors++; $display("FAIL sym_latch got %b->%b exp 1->0", obs_sym_pre, obs_sym_done); end
      checks++; if (obs_cap[0] !== 60'h801C001234007FF) begin errors++; $display("FAIL sym_bits got %h exp 801c001234007ff", obs_cap[0]); end
      do_commit(1'b1, 1'b0, '0, '0);
      observe(70, 0, 0, 1'b0, '0, '0, 1'b0, 1'b1);
      checks++; if (obs_cap[0] !== 60'h801C001234007FF) begin errors++; $display("FAIL range_bits got %h exp 801c001234007ff", obs_cap[0]); end
      checks++; if (obs_sym_done !== 1'b1) begin errors++; $display("FAIL sym_set got %b exp 1", obs_sym_done); end
   endtask

   task automatic test_reset_mid_load;
      do_commit(1'b1, 1'b0, '0, '0);
      for (int n = 1; n <= 21; n++) begin
         @(negedge clk);
         commit = 1'b0;
         if (n == 21) begin
            checks++; if (coeff_load !== 1'b1) begin errors++; $display("FAIL mid_loading got %b exp 1", coeff_load); end
            rst = 1'b1;
         end
      end
      @(negedge clk);
      checks++; if (coeff_load !== 1'b0) begin errors++; $display("FAIL midrst_coeff_load got %b exp 0", coeff_load); end
      checks++; if (hold !== 1'b0)       begin errors++; $display("FAIL midrst_hold got %b exp 0", hold); end
      checks++; if (sym_coeffs !== 1'b0) begin errors++; $display("FAIL midrst_sym got %b exp 0", sym_coeffs); end
      rst = 1'b0;
`ifdef FIR_COEFF_READBACK_EN
      for (int i = 0; i < 8; i++) begin
         rd_addr = AW'(i); #1;
         checks++; if (rd_data !== '0) begin errors++; $display("FAIL midrst_readback%0d got %h exp 0", i, rd_data); end
      end
`endif
      // No stale pending load may start after reset.
      observe(70, 0, 0, 1'b0, '0, '0, 1'b0, 1'b0);
      checks++; if (obs_nld !== 0 || obs_ndone !== 0) begin errors++; $display("FAIL midrst_idle got %0d bits %0d done exp 0 0", obs_nld, obs_ndone); end
   endtask

   initial begin
      test_reset;
      test_load;
      test_busy_wait;
      test_back_to_back;
      test_sym_and_range;
      test_reset_mid_load;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
